// File: rtl/ay8500_input_pkg.sv
// Shared types and defaults for the ay38500 paddle/pot input emulation.
package ay8500_input_pkg;

    typedef enum logic [1:0] {
        DIGITAL  = 2'd0,
        ANALOG_Y = 2'd1,
        ANALOG_X = 2'd2,
        PADDLE   = 2'd3
    } pot_mode_t;

    localparam logic [7:0] POS_RESET_DEF    = 8'd128;
    localparam logic [7:0] STEP_SLOW_DEF    = 8'd5;
    localparam logic [7:0] STEP_FAST_DEF    = 8'd8;
    localparam logic [3:0] ACCEL_FRAMES_DEF = 4'd8;
    localparam logic [3:0] HOLD_MAX         = 4'd15;

    // Signed stick byte to unsigned offset-binary (0x80 -> 0x00, 0x7F -> 0xFF).
    function automatic logic [7:0] stick_to_pos(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registered rising-edge detector; the pulse is combinational from the live input.
module sync_edge_detect (
    input  logic clk_sys,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sig_d <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/paddle_pot_emu.sv
// Per-player pot emulator: captures a paddle position each frame and counts it
// down once per line, releasing pot_out at zero like a discharging RC network.
module paddle_pot_emu
    import ay8500_input_pkg::*;
#(
    parameter logic [7:0] POS_RESET    = POS_RESET_DEF,
    parameter logic [7:0] STEP_SLOW    = STEP_SLOW_DEF,
    parameter logic [7:0] STEP_FAST    = STEP_FAST_DEF,
    parameter logic [3:0] ACCEL_FRAMES = ACCEL_FRAMES_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic [1:0]  mode,
    input  logic        invert,
    input  logic        fast,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [15:0] analog,
    input  logic [7:0]  paddle,
    output logic        pot_out,
    output logic [7:0]  pos
);

    logic       hs_rise;
    logic       vs_rise;
    logic [7:0] cap;
    logic [3:0] hold;
    logic       last_up;

    sync_edge_detect u_hs_edge (.clk_sys(clk_sys), .reset(reset), .sig(hs), .rise(hs_rise));
    sync_edge_detect u_vs_edge (.clk_sys(clk_sys), .reset(reset), .sig(vs), .rise(vs_rise));

    pot_mode_t  mode_sel;
    logic [7:0] src;
    logic [7:0] cap_load;
    logic       one_btn;
    logic [3:0] hold_eff;
    logic [8:0] step;
    logic [8:0] sum;
    logic [7:0] pos_next;
    logic [3:0] hold_next;

    assign mode_sel = pot_mode_t'(mode);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        src = pos;
        unique case (mode_sel)
            DIGITAL:  src = pos;
            ANALOG_Y: src = stick_to_pos(analog[15:8]);
            ANALOG_X: src = stick_to_pos(analog[7:0]);
            PADDLE:   src = paddle;
        endcase
        cap_load = src ^ {8{invert}};
    end

    // A direction change restarts acceleration before this frame's step is chosen.
    always_comb begin
        one_btn  = btn_up ^ btn_down;
        hold_eff = (btn_up != last_up) ? 4'd0 : hold;
        step     = {1'b0, (fast ? STEP_FAST : STEP_SLOW)};
        if (hold_eff >= ACCEL_FRAMES) begin
            step = step << 1;
        end
        sum       = btn_up ? ({1'b0, pos} - step) : ({1'b0, pos} + step);
        pos_next  = pos;
        hold_next = 4'd0;
        if (one_btn) begin
            if (sum[8]) begin
                pos_next = btn_up ? 8'h00 : 8'hFF;
            end else begin
                pos_next = sum[7:0];
            end
            hold_next = (hold_eff == HOLD_MAX) ? HOLD_MAX : hold_eff + 4'd1;
        end
    end

    // NOTE: the whole state, including the pot output flop, resets asynchronously so pot_out is high at once.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pos     <= POS_RESET;
            hold    <= 4'd0;
            last_up <= 1'b0;
            cap     <= 8'd0;
            pot_out <= 1'b1;
        end else begin
            if (vs_rise) begin
                cap <= cap_load;
                if (mode_sel == DIGITAL) begin
                    pos  <= pos_next;
                    hold <= hold_next;
                    if (one_btn) begin
                        last_up <= btn_up;
                    end
                end
            end else if (hs_rise && cap != 8'd0) begin
                cap <= cap - 8'd1;
            end
            pot_out <= (cap == 8'd0);
        end
    end

endmodule
